// File: rtl/registro_datos_spi.sv
// registro_datos_spi
// Dual-port register file shared between the SPI transfer engine (port 1)
// and the host/bus side (port 2). Synchronous writes, combinational reads,
// asynchronous clear, and a hold input that freezes every word.
module registro_datos_spi #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr1_i,
    input  logic                  wr2_i,
    input  logic                  hold_ctrl_i,
    input  logic [N-1:0]          addr_1_i,
    input  logic [N-1:0]          addr_2_i,
    input  logic [DATA_WIDTH-1:0] data_in1_i,
    input  logic [DATA_WIDTH-1:0] data_in2_i,
    output logic [DATA_WIDTH-1:0] data1_o,
    output logic [DATA_WIDTH-1:0] data2_o
);

    localparam int DEPTH = 2**N;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Per-word write strobes. Port 1 is the SPI side and owns a colliding
    // address, so port 2 is masked wherever port 1 is also writing.
    logic [DEPTH-1:0] we1;
    logic [DEPTH-1:0] we2;

    // Decode write enables into one-hot word strobes, gated by hold.
    always_comb begin
        we1 = '0;
        we2 = '0;
        if (!hold_ctrl_i) begin
            if (wr1_i) we1[addr_1_i] = 1'b1;
            if (wr2_i) we2[addr_2_i] = 1'b1;
        end
        we2 = we2 & ~we1;
    end

    // Storage: cleared asynchronously on reset, otherwise loaded per strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
        end else begin
            for (int w = 0; w < DEPTH; w++) begin
                if (we1[w])      mem[w] <= data_in1_i;
                else if (we2[w]) mem[w] <= data_in2_i;
            end
        end
    end

    // Combinational reads; the stored words are already zero during reset.
    always_comb begin
        data1_o = mem[addr_1_i];
        data2_o = mem[addr_2_i];
    end

endmodule

// File: tb/tb_registro_datos_spi.sv
// Directed bench for registro_datos_spi (N=2, DATA_WIDTH=32).
module tb_registro_datos_spi;

    logic        clk;
    logic        rst;
    logic        wr1, wr2, hold;
    logic [1:0]  a1, a2;
    logic [31:0] d1, d2;
    logic [31:0] q1, q2;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] model [4];

    registro_datos_spi #(.N(2), .DATA_WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr1_i      (wr1),
        .wr2_i      (wr2),
        .hold_ctrl_i(hold),
        .addr_1_i   (a1),
        .addr_2_i   (a2),
        .data_in1_i (d1),
        .data_in2_i (d2),
        .data1_o    (q1),
        .data2_o    (q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then step 1 time unit past it before checking/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read every address through both ports and compare with the model.
    task automatic sweep(input string tag);
        for (int i = 0; i < 4; i++) begin
            a1 = 2'(i);
            a2 = 2'(3 - i);
            #1;
            check({tag, "_p1"}, q1, model[i]);
            check({tag, "_p2"}, q2, model[3 - i]);
        end
    endtask

    initial begin
        rst = 1'b1; wr1 = 1'b0; wr2 = 1'b0; hold = 1'b0;
        a1 = '0; a2 = '0; d1 = '0; d2 = '0;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;

        // Reset: outputs read zero everywhere, writes during reset ignored
        #2;
        wr1 = 1'b1; d1 = 32'hDEAD_BEEF;
        tick();
        tick();
        wr1 = 1'b0;
        sweep("reset_held");
        rst = 1'b0;
        tick();
        sweep("after_reset");

        // Port-1 write, readback on both ports
        a1 = 2'd0; d1 = 32'h25; wr1 = 1'b1;
        #1;
        check("p1_no_bypass", q1, 32'h0);
        tick();
        wr1 = 1'b0;
        model[0] = 32'h25;
        check("p1_write_q1", q1, 32'h25);
        a2 = 2'd0;
        #1;
        check("p1_write_q2", q2, 32'h25);

        // Port-2 write
        a2 = 2'd1; d2 = 32'h12; wr2 = 1'b1;
        tick();
        wr2 = 1'b0;
        model[1] = 32'h12;
        a1 = 2'd1;
        #1;
        check("p2_write_q1", q1, 32'h12);
        check("p2_write_q2", q2, 32'h12);
        a1 = 2'd0;
        #1;
        check("p2_write_keep0", q1, 32'h25);

        // Hold on port 1: ten blocked edges, then release
        hold = 1'b1; a1 = 2'd0; d1 = 32'h1234; wr1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold1_frozen", q1, 32'h25);
        end
        hold = 1'b0;
        #1;
        check("hold1_release_pre", q1, 32'h25);
        tick();
        wr1 = 1'b0;
        model[0] = 32'h1234;
        check("hold1_release", q1, 32'h1234);

        // Hold on port 2
        hold = 1'b1; a2 = 2'd2; d2 = 32'h5678; wr2 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold2_frozen", q2, 32'h0);
        end
        hold = 1'b0;
        tick();
        wr2 = 1'b0;
        model[2] = 32'h5678;
        check("hold2_release", q2, 32'h5678);
        sweep("after_hold");

        // Collision: port 1 wins
        a1 = 2'd3; a2 = 2'd3; d1 = 32'hAAAA; d2 = 32'h5555;
        wr1 = 1'b1; wr2 = 1'b1;
        tick();
        wr1 = 1'b0; wr2 = 1'b0;
        model[3] = 32'hAAAA;
        check("collide_q1", q1, 32'hAAAA);
        check("collide_q2", q2, 32'hAAAA);

        // Simultaneous writes to distinct addresses both land
        a1 = 2'd1; a2 = 2'd2; d1 = 32'h1111; d2 = 32'h2222;
        wr1 = 1'b1; wr2 = 1'b1;
        tick();
        wr1 = 1'b0; wr2 = 1'b0;
        model[1] = 32'h1111;
        model[2] = 32'h2222;
        check("dual_q1", q1, 32'h1111);
        check("dual_q2", q2, 32'h2222);

        // Read independence: every address pair, no writes, across edges
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a1 = 2'(i); a2 = 2'(j);
                #1;
                check("rd_pair_q1", q1, model[i]);
                check("rd_pair_q2", q2, model[j]);
            end
            tick();
        end
        sweep("after_reads");

        // Mid-run reset with a write pending: clears immediately, write lost
        a1 = 2'd0; d1 = 32'hFFFF; wr1 = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("midrst_immediate", q1, 32'h0);
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        tick();
        wr1 = 1'b0;
        sweep("midrst_held");
        rst = 1'b0;
        tick();
        sweep("midrst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
